// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU with iterative shifter (ALU_FAST_SHIFT_EN selects a barrel shifter)
module alu_multicycle #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_LUI = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;

  logic [1:0]             state;
  logic [DATA_WIDTH-1:0]  work;
  logic [DATA_WIDTH-1:0]  result;
  logic [SHAMT_WIDTH-1:0] count;
  logic                   shift_left;

  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   is_shift;
  logic                   go_shift;
  logic [DATA_WIDTH-1:0]  comb_result;
  logic [DATA_WIDTH-1:0]  work_step;

  assign shamt    = B_i[SHAMT_WIDTH-1:0];
  assign is_shift = (ALU_Operation_i == OP_SRL) || (ALU_Operation_i == OP_SLL);

`ifdef ALU_FAST_SHIFT_EN
  assign go_shift = 1'b0;
`else
  assign go_shift = is_shift && (shamt != '0);
`endif

  // Single-cycle result; in the iterative build shifts only reach here with shamt 0.
  always_comb begin
    comb_result = '0;
    case (ALU_Operation_i)
      OP_ADD: comb_result = A_i + B_i;
      OP_SUB: comb_result = A_i - B_i;
      OP_AND: comb_result = A_i & B_i;
      OP_OR:  comb_result = A_i | B_i;
      OP_XOR: comb_result = A_i ^ B_i;
      OP_LUI: comb_result = B_i << 12;
`ifdef ALU_FAST_SHIFT_EN
      OP_SRL: comb_result = A_i >> shamt;
      OP_SLL: comb_result = A_i << shamt;
`else
      OP_SRL: comb_result = A_i;
      OP_SLL: comb_result = A_i;
`endif
      default: comb_result = '0;
    endcase
  end

  assign work_step = shift_left ? (work << 1) : (work >> 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      work       <= '0;
      result     <= '0;
      count      <= '0;
      shift_left <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (go_shift) begin
              work       <= A_i;
              count      <= shamt;
              shift_left <= (ALU_Operation_i == OP_SLL);
              state      <= SHIFT;
            end else begin
              result <= comb_result;
              state  <= DONE;
            end
          end
        end
        SHIFT: begin
          work  <= work_step;
          count <= count - 1'b1;
          // Last step: publish the final shifted value directly.
          if (count == SHAMT_WIDTH'(1)) begin
            result <= work_step;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);
  assign ALU_Result_o = result;
  assign Zero_o       = (result == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle
module tb_alu_multicycle;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_LUI = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [3:0]  ALU_Operation_i;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] ALU_Result_o;
  logic        Zero_o;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          issue;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  alu_multicycle #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk             (clk),
    .reset           (rst_n),
    .start_i         (start_i),
    .ALU_Operation_i (ALU_Operation_i),
    .A_i             (A_i),
    .B_i             (B_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .ALU_Result_o    (ALU_Result_o),
    .Zero_o          (Zero_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int shift_lat(input int k);
    if (FAST || k == 0) return 1;
    return k + 1;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done_o) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", ALU_Result_o, e.res);
        chk("zero", {31'd0, Zero_o}, {31'd0, (e.res == 32'd0)});
        chk("latency", cyc - e.issue, e.lat);
      end
    end
  end

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int lat, input bit push);
    @(negedge clk);
    ALU_Operation_i = op;
    A_i = a;
    B_i = b;
    start_i = 1'b1;
    if (push) q.push_back('{exp_res, lat, cyc});
    @(negedge clk);
    start_i = 1'b0;
    A_i = 32'hDEADBEEF;
    B_i = 32'h00000013;
    ALU_Operation_i = OP_XOR;
  endtask

  task automatic wait_idle(input int exp_busy);
    int n = 0;
    while (busy_o && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (exp_busy >= 0) chk("busy_cycles", n, exp_busy);
    else if (n >= 64) chk("busy_timeout", n, 0);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input int lat);
    launch(op, a, b, exp_res, lat, 1'b1);
    wait_idle(lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_i = 1'b1;
    ALU_Operation_i = OP_ADD;
    A_i = 32'd5;
    B_i = 32'd7;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_result", ALU_Result_o, 32'd0);
      chk("rst_zero", {31'd0, Zero_o}, 32'd1);
    end
    start_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, busy_o}, 32'd0);

    run(OP_ADD, 32'hFFFFFFFF, 32'd1, 32'h00000000, 1);
    run(OP_SUB, 32'd3, 32'd5, 32'hFFFFFFFE, 1);
    run(OP_SLL, 32'h00000001, 32'd31, 32'h80000000, shift_lat(31));
    run(OP_SRL, 32'h80000000, 32'h00000020, 32'h80000000, 1);
    run(OP_LUI, 32'h0, 32'h00012345, 32'h12345000, 1);
    run(4'b1111, 32'h1234, 32'h5678, 32'h00000000, 1);
    run(OP_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1);
    run(OP_OR, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1);
    run(OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1);
    run(OP_SRL, 32'h80000000, 32'd1, 32'h40000000, shift_lat(1));
    run(OP_SLL, 32'h12345678, 32'd4, 32'h23456780, shift_lat(4));

    // Start pulse while busy must be dropped.
    launch(OP_SRL, 32'hF0000000, 32'd4, 32'h0F000000, shift_lat(4), 1'b1);
    if (!FAST) begin
      @(negedge clk);
      start_i = 1'b1;
      ALU_Operation_i = OP_XOR;
      A_i = 32'h12345678;
      B_i = 32'hFFFFFFFF;
      @(negedge clk);
      start_i = 1'b0;
    end
    wait_idle(-1);
    repeat (3) @(negedge clk);

    // Reset mid-shift discards the operation.
    launch(OP_SLL, 32'h00000003, 32'd10, 32'h00000C00, 1, FAST);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_done", {31'd0, done_o}, 32'd0);
    chk("midrst_result", ALU_Result_o, 32'd0);
    chk("midrst_zero", {31'd0, Zero_o}, 32'd1);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_stays_idle", {31'd0, busy_o}, 32'd0);

    run(OP_AND, 32'h000000FF, 32'h0000000F, 32'h0000000F, 1);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
